// File: rtl/add_sub_multicycle.sv
// Multi-cycle two's complement adder/subtractor.
// The operation is latched on start and processed CHUNK bits per cycle,
// LSB slice first, through a single CHUNK-bit adder with a carry register.
// Final result and flags are registered on entry to DONE; optional
// saturation clamps the result on signed overflow.
//
// Handshake: start is sampled only while idle (busy=0); a request seen while
// busy is dropped, never queued. done is a one-cycle pulse that marks Sum and
// the flags as valid; they hold that value until the next done pulse.
module add_sub_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             ovfl,
  output logic             neg,
  output logic             zero,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched operands: b_q already holds B inverted for subtraction, and the
  // carry register is seeded with sub, so RUN only ever adds.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sat_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] part;

  logic             accept;
  logic             last;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] raw;
  logic             ovfl_c;
  logic [WIDTH-1:0] sum_c;

  assign accept    = (state == IDLE) && start;
  assign last      = (idx == LAST_IDX);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Current slice add and the final result/flags it would produce
  always_comb begin
    shamt     = 32'(idx) * 32'(CHUNK);
    slice_a   = CHUNK'(a_q >> shamt);
    slice_b   = CHUNK'(b_q >> shamt);
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
    // part has zeros above the slices already done, so OR-ing places the slice
    raw       = part | (WIDTH'(slice_sum[CHUNK-1:0]) << shamt);
    ovfl_c    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
    sum_c     = raw;
    if (sat_q && ovfl_c) begin
      sum_c = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Operand latch, slice accumulation and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sat_q <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      part  <= '0;
      Sum   <= '0;
      ovfl  <= 1'b0;
      neg   <= 1'b0;
      zero  <= 1'b0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B ^ {WIDTH{sub}};
      sat_q <= sat;
      carry <= sub;
      idx   <= '0;
      part  <= '0;
    end else if (state == RUN) begin
      part  <= raw;
      carry <= slice_sum[CHUNK];
      if (!last) begin
        idx <= idx + 1'b1;
      end else begin
        Sum  <= sum_c;
        ovfl <= ovfl_c;
        neg  <= sum_c[WIDTH-1];
        zero <= (sum_c == '0);
        cout <= slice_sum[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_add_sub_multicycle.sv
// Bench for add_sub_multicycle: directed vector table, hand-written
// multi-cycle sequences, randomized operations against an arithmetic model,
// and an 8-bit single-chunk instance.
module tb_add_sub_multicycle;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-chunk instance
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         busy, done, ovfl, neg, zero, cout;
  logic [W-1:0] Sum;
  logic [1:0]   state_dbg;

  add_sub_multicycle #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sub(sub), .sat(sat),
    .busy(busy), .done(done), .Sum(Sum), .ovfl(ovfl), .neg(neg), .zero(zero),
    .cout(cout), .state_dbg(state_dbg)
  );

  // 8-bit, single-chunk instance
  logic       start8 = 1'b0;
  logic [7:0] A8 = '0;
  logic [7:0] B8 = '0;
  logic       sub8 = 1'b0;
  logic       sat8 = 1'b0;
  logic       busy8, done8, ovfl8, neg8, zero8, cout8;
  logic [7:0] Sum8;
  logic [1:0] state_dbg8;

  add_sub_multicycle #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .sub(sub8), .sat(sat8),
    .busy(busy8), .done(done8), .Sum(Sum8), .ovfl(ovfl8), .neg(neg8), .zero(zero8),
    .cout(cout8), .state_dbg(state_dbg8)
  );

  // Scoreboard: {Sum, ovfl, neg, zero, cout}
  logic [W+3:0] exp_q[$];
  logic [W-1:0] last_sum = '0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic t);
    int sa, sb, r, ua, ub;
    logic o, co, ng, z;
    logic [W-1:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = s ? (sa - sb) : (sa + sb);
    co = s ? (ua >= ub) : ((ua + ub) > 65535);
    o  = (r > 32767) || (r < -32768);
    res = r[W-1:0];
    if (o && t) res = (r > 0) ? 16'h7FFF : 16'h8000;
    ng = res[W-1];
    z  = (res == '0);
    return {res, o, ng, z, co};
  endfunction

  // Driver: one full operation, with inputs scrambled after acceptance
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic t, output logic [W+3:0] got);
    int edges;
    logic [W+3:0] exp;
    exp_q.push_back(model(a, b, s, t));
    @(negedge clk);
    A = a; B = b; sub = s; sat = t; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    sub = 1'($urandom); sat = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    for (edges = 1; edges <= 12; edges++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
      check("busy_run", 32'(busy), 32'd1);
      check("sum_hold", 32'(Sum), 32'(last_sum));
    end
    check("done_latency", 32'(edges), 32'(N));
    check("busy_at_done", 32'(busy), 32'd1);
    got = {Sum, ovfl, neg, zero, cout};
    exp = exp_q.pop_front();
    check("scoreboard", 32'(got), 32'(exp));
    last_sum = exp[W+3:4];
    @(posedge clk);
    @(negedge clk);
    check("done_drop", 32'(done), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("sum_after_done", 32'(Sum), 32'(last_sum));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         t;
    logic [W-1:0] sum;
    logic [3:0]   flags; // {ovfl, neg, zero, cout}
  } vec_t;

  vec_t vecs[11];
  logic [W-1:0] corner[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W+3:0] got;
    int edges;
    int n_done;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 4'b0000};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b1100};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b1000};
    vecs[3]  = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 4'b0011};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1101};
    vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0011};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 4'b1101};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b1011};
    vecs[8]  = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 4'b0100};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 4'b1000};
    vecs[10] = '{16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'b0000};
    corner[0] = 16'h0000; corner[1] = 16'h7FFF;
    corner[2] = 16'h8000; corner[3] = 16'hFFFF;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_flags", 32'({ovfl, neg, zero, cout}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].t, got);
      check($sformatf("vec%0d_sum", i), 32'(got[W+3:4]), 32'(vecs[i].sum));
      check($sformatf("vec%0d_flags", i), 32'(got[3:0]), 32'(vecs[i].flags));
    end

    // start while busy is ignored
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; sub = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk);                       // edge 0
    @(negedge clk); start = 1'b0;
    @(posedge clk);                       // edge 1
    @(negedge clk); start = 1'b1; A = 16'h1111; B = 16'h2222;
    @(posedge clk);                       // edge 2
    @(negedge clk); start = 1'b0;
    for (edges = 3; edges <= 12; edges++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    check("ignore_latency", 32'(edges), 32'd4);
    check("ignore_sum", 32'(Sum), 32'h0002);
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    check("ignore_no_second_done", 32'(n_done), 32'd0);
    check("ignore_idle", 32'(busy), 32'd0);
    last_sum = 16'h0002;

    // Reset in the middle of RUN
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; start = 1'b1;
    @(posedge clk);                       // edge 0
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(Sum), 32'd0);
    check("midrst_flags", 32'({ovfl, neg, zero, cout}), 32'd0);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    rst_n = 1'b1;
    last_sum = '0;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, got);
    check("postrst_sum", 32'(got[W+3:4]), 32'h0000);
    check("postrst_flags", 32'(got[3:0]), 32'b0011);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ra = (i % 4 == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      rb = (i % 3 == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      do_op(ra, rb, 1'($urandom), 1'($urandom), got);
    end

    // Single-chunk instance
    @(negedge clk);
    A8 = 8'h7F; B8 = 8'h01; sub8 = 1'b0; sat8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    check("n1_busy_run", 32'(busy8), 32'd1);
    check("n1_done_early", 32'(done8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("n1_done", 32'(done8), 32'd1);
    check("n1_sum", 32'(Sum8), 32'h7F);
    check("n1_flags", 32'({ovfl8, neg8, zero8, cout8}), 32'b1000);
    @(posedge clk);
    @(negedge clk);
    check("n1_done_drop", 32'(done8), 32'd0);
    check("n1_idle", 32'(busy8), 32'd0);
    A8 = 8'h40; B8 = 8'h20; sat8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("n1b_done", 32'(done8), 32'd1);
    check("n1b_sum", 32'(Sum8), 32'h60);
    check("n1b_flags", 32'({ovfl8, neg8, zero8, cout8}), 32'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
